wb_to_avalon_burst_bridge: RTL and testbench

//  Wishbone B3 slave to Avalon-MM master bridge, successor to the single-beat/pipelined bridge.

---
 rtl/wb_to_avalon_burst_bridge.sv | 149 ++++++++++++++
 tb/tb_wb_to_avalon_burst_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_to_avalon_burst_bridge.sv
// Wishbone B3 slave to Avalon-MM master; linear WB read bursts become Avalon bursts of BURST_LEN.
// Define AV_TIMEOUT_EN to add a stall watchdog that aborts hung transfers with wb_err_o.
module wb_to_avalon_burst_bridge #(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int BURST_LEN      = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int BCW           = $clog2(BURST_LEN) + 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [DW-1:0]     wb_dat_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic [2:0]        wb_cti_i,
  input  logic [1:0]        wb_bte_i,
  output logic [DW-1:0]     wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  output logic [AW-1:0]     m_av_address_o,
  output logic [DW/8-1:0]   m_av_byteenable_o,
  output logic              m_av_read_o,
  output logic              m_av_write_o,
  output logic [BCW-1:0]    m_av_burstcount_o,
  output logic              m_av_burstbegin_o,
  output logic [DW-1:0]     m_av_writedata_o,
  input  logic              m_av_waitrequest_i,
  input  logic              m_av_readdatavalid_i,
  input  logic [DW-1:0]     m_av_readdata_i
);

  localparam int            BEW       = DW / 8;
  localparam int            CW        = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [AW-1:0] ADR_MASK  = ~AW'(BEW - 1);
  localparam logic [2:0]    CTI_INCR  = 3'b010;
  localparam logic [2:0]    CTI_EOB   = 3'b111;

  if (BURST_LEN < 2 || BURST_LEN > 64 || DW < 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536)
  begin : g_bad_params
    $error("wb_to_avalon_burst_bridge: unsupported parameter set");
  end

  typedef enum logic [2:0] {IDLE, SRD, BREQ, BDATA, DRAIN, WACK} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] beat_cnt;
  logic          req, lin_burst, last_beat, timeout;

  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign lin_burst = ~wb_we_i & (wb_cti_i == CTI_INCR) & (wb_bte_i == 2'b00);
  assign last_beat = m_av_readdatavalid_i & (beat_cnt == LAST_BEAT);
  assign wb_dat_o  = m_av_readdata_i;
  assign wb_rty_o  = 1'b0;

  // SRD also carries single writes until accepted; a read ack waits for the request to be taken.
  assign wb_ack_o = (state == WACK)
                  | ((state == SRD) & ~m_av_read_o & ~m_av_write_o & m_av_readdatavalid_i)
                  | ((state == BDATA) & m_av_readdatavalid_i & wb_cyc_i & wb_stb_i);

`ifdef AV_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] stall_cnt;
  logic        stalled;

  assign stalled  = (state != IDLE) & m_av_waitrequest_i & ~m_av_readdatavalid_i;
  assign timeout  = stalled & (stall_cnt == TIMEOUT_LAST);
  assign wb_err_o = timeout & wb_cyc_i & wb_stb_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)    stall_cnt <= '0;
    else if (!stalled) stall_cnt <= '0;
    else               stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign timeout  = 1'b0;
  assign wb_err_o = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req) state_nxt = lin_burst ? BREQ : SRD;
      SRD: begin
        if (m_av_write_o) begin
          if (!m_av_waitrequest_i) state_nxt = WACK;
        end else if (wb_ack_o) begin
          state_nxt = IDLE;
        end
      end
      BREQ:  if (!m_av_waitrequest_i) state_nxt = BDATA;
      BDATA: begin
        if (last_beat)
          state_nxt = IDLE;
        else if ((wb_ack_o && wb_cti_i == CTI_EOB) || !wb_cyc_i)
          state_nxt = DRAIN;
      end
      DRAIN: if (last_beat) state_nxt = IDLE;
      WACK:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state             <= IDLE;
      m_av_read_o       <= 1'b0;
      m_av_write_o      <= 1'b0;
      m_av_burstbegin_o <= 1'b0;
      m_av_address_o    <= '0;
      m_av_burstcount_o <= BCW'(1);
      beat_cnt          <= '0;
    end else begin
      state             <= state_nxt;
      m_av_burstbegin_o <= 1'b0;
      if (state == IDLE) begin
        beat_cnt <= '0;
        if (req) begin
          m_av_read_o       <= ~wb_we_i;
          m_av_write_o      <= wb_we_i;
          m_av_burstbegin_o <= 1'b1;
          m_av_address_o    <= lin_burst ? (wb_adr_i & ADR_MASK) : wb_adr_i;
          m_av_burstcount_o <= lin_burst ? BCW'(BURST_LEN) : BCW'(1);
        end
      end else begin
        if (timeout || !m_av_waitrequest_i) begin
          m_av_read_o  <= 1'b0;
          m_av_write_o <= 1'b0;
        end
        // Beat counter wraps to zero on the last beat since BURST_LEN is a power of two.
        if ((state == BDATA || state == DRAIN) && m_av_readdatavalid_i)
          beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (state == IDLE && req) begin
      m_av_writedata_o  <= wb_dat_i;
      m_av_byteenable_o <= lin_burst ? '1 : wb_sel_i;
    end
  end

endmodule

// File: tb/tb_wb_to_avalon_burst_bridge.sv
// Directed bench for wb_to_avalon_burst_bridge: a cycle-stepped WB master and Avalon slave model.
module tb_wb_to_avalon_burst_bridge;

  localparam int          DW  = 32;
  localparam int          AW  = 32;
  localparam int          BL  = 8;
  localparam int          BCW = $clog2(BL) + 1;
  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]   wb_adr = '0;
  logic [DW-1:0]   wb_dat = '0;
  logic [DW/8-1:0] wb_sel = '0;
  logic            wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
  logic [2:0]      wb_cti = '0;
  logic [1:0]      wb_bte = '0;
  logic [DW-1:0]   wb_rdat;
  logic            wb_ack, wb_err, wb_rty;
  logic [AW-1:0]   av_addr;
  logic [DW/8-1:0] av_be;
  logic            av_rd, av_wr, av_bb;
  logic [BCW-1:0]  av_bc;
  logic [DW-1:0]   av_wdat;
  logic            av_wait = 1'b0, av_rdv = 1'b0;
  logic [DW-1:0]   av_rdata = '0;

  wb_to_avalon_burst_bridge #(
    .DW(DW), .AW(AW), .BURST_LEN(BL), .TIMEOUT_CYCLES(16)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
    .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
    .wb_cti_i(wb_cti), .wb_bte_i(wb_bte),
    .wb_dat_o(wb_rdat), .wb_ack_o(wb_ack), .wb_err_o(wb_err), .wb_rty_o(wb_rty),
    .m_av_address_o(av_addr), .m_av_byteenable_o(av_be),
    .m_av_read_o(av_rd), .m_av_write_o(av_wr),
    .m_av_burstcount_o(av_bc), .m_av_burstbegin_o(av_bb),
    .m_av_writedata_o(av_wdat),
    .m_av_waitrequest_i(av_wait), .m_av_readdatavalid_i(av_rdv),
    .m_av_readdata_i(av_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Avalon slave model
  int          wait_left = 0;
  bit          stuck = 1'b0;
  int          lat = 1;
  int          gap [8] = '{0, 2, 1, 0, 3, 0, 1, 0};
  int          sl_pend = 0, sl_beat = 0, sl_delay = 0;
  logic [31:0] sl_addr = '0;

  // monitors
  int          n_wr_cyc, n_rd_cyc, n_bb, n_rdv, n_err, first_ack, cyc_idx;
  logic [31:0] acc_addr[$];
  int          acc_bc[$];
  logic [31:0] acc_wdat[$];
  logic [3:0]  acc_be[$];
  logic [31:0] ack_dat[$];

  // WB master model
  bit m_active = 1'b0;
  int m_target = 0, m_done = 0;

  function automatic logic [31:0] rd_val(input logic [31:0] addr, input int beat);
    return (addr + 32'(beat * 4)) ^ KEY;
  endfunction

  task automatic clear_mon();
    n_wr_cyc = 0; n_rd_cyc = 0; n_bb = 0; n_rdv = 0; n_err = 0;
    first_ack = -1; cyc_idx = 0;
    acc_addr.delete(); acc_bc.delete(); acc_wdat.delete(); acc_be.delete(); ack_dat.delete();
  endtask

  task automatic start_master(input logic [31:0] adr, input bit we, input logic [31:0] dat,
                              input logic [3:0] sel, input logic [2:0] cti, input int target);
    wb_adr = adr; wb_we = we; wb_dat = dat; wb_sel = sel; wb_cti = cti; wb_bte = 2'b00;
    wb_cyc = 1'b1; wb_stb = 1'b1;
    m_active = 1'b1; m_target = target; m_done = 0;
  endtask

  task automatic end_master();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_cti = 3'b000; m_active = 1'b0;
  endtask

  // Sample at the falling edge, then drive the next cycle's inputs 1 ns after the rising edge.
  task automatic one_cycle();
    bit ack_now, err_now;
    @(negedge clk);
    if (av_wr) n_wr_cyc++;
    if (av_rd) n_rd_cyc++;
    if (av_bb) n_bb++;
    if ((av_rd || av_wr) && !av_wait) begin
      acc_addr.push_back(av_addr); acc_bc.push_back(int'(av_bc));
      acc_wdat.push_back(av_wdat); acc_be.push_back(av_be);
      if (av_rd) begin
        sl_pend = int'(av_bc); sl_beat = 0; sl_addr = av_addr;
        sl_delay = (lat > 0) ? lat - 1 : 0;
      end
    end
    if (av_rdv) n_rdv++;
    ack_now = wb_ack; err_now = wb_err;
    if (wb_ack) begin
      ack_dat.push_back(wb_rdat);
      if (first_ack < 0) first_ack = cyc_idx;
    end
    if (wb_err) n_err++;
    @(posedge clk); #1;
    cyc_idx++;
    if (av_rd || av_wr) begin
      if (stuck) av_wait = 1'b1;
      else if (wait_left > 0) begin av_wait = 1'b1; wait_left--; end
      else av_wait = 1'b0;
    end else begin
      av_wait = stuck;
    end
    av_rdv = 1'b0;
    if (sl_pend > 0) begin
      if (sl_delay > 0) sl_delay--;
      else begin
        av_rdv = 1'b1; av_rdata = rd_val(sl_addr, sl_beat);
        sl_beat++; sl_pend--; sl_delay = gap[sl_beat % 8];
      end
    end
    if (m_active) begin
      if (err_now) end_master();
      else if (ack_now) begin
        m_done++;
        if (m_done == m_target) end_master();
        else begin
          wb_adr = wb_adr + 32'd4;
          if (m_done == m_target - 1 && wb_cti == 3'b010) wb_cti = 3'b111;
        end
      end
    end
  endtask

  task automatic run(input int budget, input string tag);
    int n = 0;
    while ((m_active || sl_pend > 0) && n < budget) begin
      one_cycle();
      n++;
    end
    check({tag, "_complete"}, 64'(m_active || sl_pend > 0), 64'd0);
    one_cycle();
    one_cycle();
  endtask

  initial begin
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_read", 64'(av_rd), 64'd0);
    check("rst_write", 64'(av_wr), 64'd0);
    check("rst_bb", 64'(av_bb), 64'd0);
    check("rst_ack", 64'(wb_ack), 64'd0);
    check("rst_err", 64'(wb_err), 64'd0);
    check("rst_rty", 64'(wb_rty), 64'd0);
    check("rst_addr", 64'(av_addr), 64'd0);
    check("rst_bc", 64'(av_bc), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    one_cycle();

    // single write with 3 waitrequest cycles
    clear_mon(); wait_left = 3;
    start_master(32'h100, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000, 1);
    run(50, "wr1");
    check("wr1_write_cycles", 64'(n_wr_cyc), 64'd4);
    check("wr1_acks", 64'(ack_dat.size()), 64'd1);
    check("wr1_ack_cycle", 64'(first_ack), 64'd5);
    check("wr1_addr", 64'(acc_addr[0]), 64'h100);
    check("wr1_wdata", 64'(acc_wdat[0]), 64'hDEAD_BEEF);
    check("wr1_be", 64'(acc_be[0]), 64'hF);
    check("wr1_bc", 64'(acc_bc[0]), 64'd1);

    // classic read, data 5 cycles after acceptance
    clear_mon(); lat = 5;
    start_master(32'h200, 1'b0, '0, 4'hF, 3'b000, 1);
    run(50, "rd1");
    check("rd1_read_cycles", 64'(n_rd_cyc), 64'd1);
    check("rd1_bc", 64'(acc_bc[0]), 64'd1);
    check("rd1_addr", 64'(acc_addr[0]), 64'h200);
    check("rd1_acks", 64'(ack_dat.size()), 64'd1);
    check("rd1_ack_cycle", 64'(first_ack), 64'd6);
    check("rd1_data", 64'(ack_dat[0]), 64'(rd_val(32'h200, 0)));

    // linear 8-beat burst from 0x1000, request held 2 cycles, gapped beats
    clear_mon(); lat = 2; wait_left = 2;
    start_master(32'h1000, 1'b0, '0, 4'h3, 3'b010, 8);
    run(100, "bu1");
    check("bu1_requests", 64'(acc_addr.size()), 64'd1);
    check("bu1_read_cycles", 64'(n_rd_cyc), 64'd3);
    check("bu1_bb", 64'(n_bb), 64'd1);
    check("bu1_addr", 64'(acc_addr[0]), 64'h1000);
    check("bu1_bc", 64'(acc_bc[0]), 64'd8);
    check("bu1_be", 64'(acc_be[0]), 64'hF);
    check("bu1_acks", 64'(ack_dat.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("bu1_beat%0d", i), 64'(ack_dat[i]), 64'(rd_val(32'h1000, i)));

    // burst from unaligned 0x300A ended after 3 beats; remaining 5 beats drained
    clear_mon(); lat = 1;
    start_master(32'h300A, 1'b0, '0, 4'hF, 3'b010, 3);
    run(100, "dr1");
    check("dr1_addr", 64'(acc_addr[0]), 64'h3008);
    check("dr1_rdv", 64'(n_rdv), 64'd8);
    check("dr1_acks", 64'(ack_dat.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("dr1_beat%0d", i), 64'(ack_dat[i]), 64'(rd_val(32'h3008, i)));
    clear_mon(); lat = 3;
    start_master(32'h400, 1'b0, '0, 4'hF, 3'b000, 1);
    run(50, "rd2");
    check("rd2_acks", 64'(ack_dat.size()), 64'd1);
    check("rd2_data", 64'(ack_dat[0]), 64'(rd_val(32'h400, 0)));

    // continuing 16-beat WB burst splits into two Avalon bursts
    clear_mon(); lat = 1;
    start_master(32'h0, 1'b0, '0, 4'hF, 3'b010, 16);
    run(200, "bu2");
    check("bu2_requests", 64'(acc_addr.size()), 64'd2);
    check("bu2_addr0", 64'(acc_addr[0]), 64'h0);
    check("bu2_addr1", 64'(acc_addr[1]), 64'h20);
    check("bu2_bc1", 64'(acc_bc[1]), 64'd8);
    check("bu2_bb", 64'(n_bb), 64'd2);
    check("bu2_acks", 64'(ack_dat.size()), 64'd16);
    for (int i = 0; i < 16; i++)
      check($sformatf("bu2_beat%0d", i), 64'(ack_dat[i]), 64'(rd_val(32'h0, i)));

    // stray readdatavalid while idle, then a zero-wait write
    clear_mon();
    av_rdv = 1'b1; av_rdata = 32'hBAD0_BAD0;
    one_cycle();
    check("stray_ack", 64'(ack_dat.size()), 64'd0);
    clear_mon();
    start_master(32'h104, 1'b1, 32'h1234_5678, 4'h6, 3'b000, 1);
    run(50, "wr2");
    check("wr2_ack_cycle", 64'(first_ack), 64'd2);
    check("wr2_write_cycles", 64'(n_wr_cyc), 64'd1);
    check("wr2_be", 64'(acc_be[0]), 64'h6);
    check("wr2_wdata", 64'(acc_wdat[0]), 64'h1234_5678);

`ifdef AV_TIMEOUT_EN
    // waitrequest stuck high: error after 16 stalled request cycles
    clear_mon(); stuck = 1'b1;
    start_master(32'h500, 1'b1, 32'hCAFE_F00D, 4'hF, 3'b000, 1);
    run(100, "to1");
    check("to1_err", 64'(n_err), 64'd1);
    check("to1_acks", 64'(ack_dat.size()), 64'd0);
    check("to1_write_cycles", 64'(n_wr_cyc), 64'd16);
    clear_mon(); stuck = 1'b0;
    start_master(32'h504, 1'b1, 32'h0BAD_CAFE, 4'hF, 3'b000, 1);
    run(50, "to2");
    check("to2_acks", 64'(ack_dat.size()), 64'd1);
    check("to2_err", 64'(n_err), 64'd0);
    check("to2_addr", 64'(acc_addr[0]), 64'h504);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
